cla_seq_adder: RTL

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

---
 rtl/cla_seq_adder_pkg.sv | 13 +
 rtl/cla_4bit.sv | 36 +++
 rtl/cla_seq_adder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cla_seq_adder_pkg.sv
// rtl/cla_seq_adder_pkg.sv - shared FSM encoding and NIB range limits for cla_seq_adder
package cla_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIB_MIN = 2;
    localparam int NIB_MAX = 8;

endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit carry-lookahead adder slice
// Ports:
//   A, B : 4-bit addends
//   Cin  : carry-in
//   S    : 4-bit sum
//   Cout : carry-out of bit 3
module cla_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded directly from generate/propagate terms so no
    // carry depends on a previous carry.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - nibble-serial adder reusing one 4-bit CLA over NIB cycles
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an addition (sampled only in IDLE)
//   a, b, cin  : operands and carry-in, captured on the accepted start
//   busy       : high while nibbles are being added
//   done       : one-cycle pulse when sum/cout/ovf are valid
//   sum        : W-bit result, filled one nibble per RUN cycle
//   cout, ovf  : final carry-out and two's-complement overflow
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int IDXW = $clog2(NIB);

    if (NIB < NIB_MIN || NIB > NIB_MAX) begin : g_nib_range
        $error("cla_seq_adder: NIB outside legal range");
    end

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic [IDXW+1:0]   bit_pos;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              carry_r;
    logic [W-1:0]      sum_r;
    logic              cout_r;
    logic              ovf_r;
    logic              last;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        nib_s;
    logic              nib_cout;
    logic              carry_into_msb;

    assign bit_pos = {idx, 2'b00};
    assign last    = (idx == IDXW'(NIB - 1));
    assign nib_a   = a_r[bit_pos +: 4];
    assign nib_b   = b_r[bit_pos +: 4];

    cla_4bit u_cla (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry_r),
        .S    (nib_s),
        .Cout (nib_cout)
    );

    // Recover the carry into bit 3 of the slice from its sum and inputs,
    // since the slice only exposes the carry out of bit 3.
    assign carry_into_msb = nib_s[3] ^ nib_a[3] ^ nib_b[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE:            state_next = ST_IDLE;
            default:            state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx     <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r[bit_pos +: 4] <= nib_s;
                    carry_r             <= nib_cout;
                    if (last) begin
                        idx    <= '0;
                        cout_r <= nib_cout;
                        ovf_r  <= nib_cout ^ carry_into_msb;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
